// File: rtl/sched_pkg.sv
// Shared definitions for the program-driven schedule sequencer and its program generator.
// Covers the state encoding, the control-word width and the field offsets.
package sched_pkg;

  localparam int unsigned N_FU_DEF  = 3;
  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned OP_W_DEF  = 2;
  localparam int unsigned N_REG_DEF = 6;
  localparam int unsigned DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned cw_w(int unsigned n_fu, int unsigned sel_w,
                                       int unsigned op_w, int unsigned n_reg);
    return 2 * n_fu * sel_w + n_fu * op_w + n_reg + 2;
  endfunction

  // Field offsets, LSB up: sel1, sel2, op, reg_en, result_en, last.
  function automatic int unsigned sel1_lsb();
    return 0;
  endfunction

  function automatic int unsigned sel2_lsb(int unsigned n_fu, int unsigned sel_w);
    return n_fu * sel_w;
  endfunction

  function automatic int unsigned op_lsb(int unsigned n_fu, int unsigned sel_w);
    return 2 * n_fu * sel_w;
  endfunction

  function automatic int unsigned ren_lsb(int unsigned n_fu, int unsigned sel_w,
                                          int unsigned op_w);
    return 2 * n_fu * sel_w + n_fu * op_w;
  endfunction

  function automatic int unsigned res_bit(int unsigned n_fu, int unsigned sel_w,
                                          int unsigned op_w, int unsigned n_reg);
    return 2 * n_fu * sel_w + n_fu * op_w + n_reg;
  endfunction

  function automatic int unsigned last_bit(int unsigned n_fu, int unsigned sel_w,
                                           int unsigned op_w, int unsigned n_reg);
    return 2 * n_fu * sel_w + n_fu * op_w + n_reg + 1;
  endfunction

endpackage

// File: rtl/sched_prog_mem.sv
// Program store: DEPTH control words, synchronous write, asynchronous read.
// Not reset; contents are meaningless until loaded.
module sched_prog_mem
  import sched_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned STEP_W = $clog2(DEPTH),
  parameter int unsigned CW_W   = cw_w(N_FU_DEF, SEL_W_DEF, OP_W_DEF, N_REG_DEF)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [STEP_W-1:0] waddr,
  input  logic [CW_W-1:0]   wdata,
  input  logic [STEP_W-1:0] raddr,
  output logic [CW_W-1:0]   rdata
);

  logic [CW_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sched_sequencer.sv
// Issues one control word per cycle from the program store to the shared datapath,
// under the host start/op_ready/done handshake with stall and abort.
module sched_sequencer
  import sched_pkg::*;
#(
  parameter int unsigned N_FU   = N_FU_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF,
  parameter int unsigned N_REG  = N_REG_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned STEP_W = $clog2(DEPTH),
  parameter int unsigned CW_W   = cw_w(N_FU, SEL_W, OP_W, N_REG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stall,
  input  logic                   prog_we,
  input  logic [STEP_W-1:0]      prog_addr,
  input  logic [CW_W-1:0]        prog_data,
  output logic                   op_ready,
  output logic                   busy,
  output logic [STEP_W-1:0]      step,
  output logic [N_FU*SEL_W-1:0]  fu_sel1,
  output logic [N_FU*SEL_W-1:0]  fu_sel2,
  output logic [N_FU*OP_W-1:0]   fu_op,
  output logic [N_REG-1:0]       reg_en,
  output logic                   result_en,
  output logic                   done
);

  localparam int unsigned SEL_TOT  = N_FU * SEL_W;
  localparam int unsigned OP_TOT   = N_FU * OP_W;
  localparam int unsigned SEL1_LSB = sel1_lsb();
  localparam int unsigned SEL2_LSB = sel2_lsb(N_FU, SEL_W);
  localparam int unsigned OP_LSB   = op_lsb(N_FU, SEL_W);
  localparam int unsigned REN_LSB  = ren_lsb(N_FU, SEL_W, OP_W);
  localparam int unsigned RES_BIT  = res_bit(N_FU, SEL_W, OP_W, N_REG);
  localparam int unsigned LAST_BIT = last_bit(N_FU, SEL_W, OP_W, N_REG);
  localparam logic [STEP_W-1:0] PC_MAX = STEP_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] pc_q, pc_d;
  logic [CW_W-1:0]   word_c;
  logic              mem_we_c;

  // Program writes are only accepted while idle.
  assign mem_we_c = prog_we && (state_q == ST_IDLE);

  sched_prog_mem #(
    .DEPTH  (DEPTH),
    .STEP_W (STEP_W),
    .CW_W   (CW_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_ready  = 1'b0;
    busy      = 1'b0;
    step      = '0;
    fu_sel1   = '0;
    fu_sel2   = '0;
    fu_op     = '0;
    reg_en    = '0;
    result_en = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        pc_d     = '0;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort outranks stall and last, and silences the datapath this cycle.
        if (abort) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end else begin
          busy    = 1'b1;
          step    = pc_q;
          fu_sel1 = word_c[SEL1_LSB +: SEL_TOT];
          fu_sel2 = word_c[SEL2_LSB +: SEL_TOT];
          fu_op   = word_c[OP_LSB +: OP_TOT];
          if (!stall) begin
            reg_en    = word_c[REN_LSB +: N_REG];
            result_en = word_c[RES_BIT];
            // The top address ends the schedule even without a last flag.
            if (word_c[LAST_BIT] || (pc_q == PC_MAX)) begin
              state_d = ST_DONE;
              pc_d    = '0;
            end else begin
              pc_d = pc_q + STEP_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        pc_d    = '0;
      end

      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

endmodule

// File: doc/sched_sequencer.md
# sched_sequencer

Program-driven successor to the fixed per-schedule datapath controllers. It issues one control word per cycle from a loadable program memory. Each word carries the operand selects and opcode for every functional unit, the destination register enables, result_en and a last-step flag. It sits between the host handshake (start/op_ready/done) and the shared ALU/LOG/MUL datapath. A new schedule is a memory load, not a new RTL module.

## Interface
- N_FU, 3: number of functional units driven.
- SEL_W, 4: operand-select width per unit input.
- OP_W, 2: opcode width per unit; narrower units use the LSBs.
- N_REG, 6: number of intermediate result registers.
- DEPTH, 16: program memory words (max schedule length).
- STEP_W, clog2(DEPTH): program counter width.
- CW_W, 2*N_FU*SEL_W + N_FU*OP_W + N_REG + 2: control word width (38 at defaults).
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin schedule; sampled only in IDLE.
- abort  in  1  terminate running schedule.
- stall  in  1  freeze current step (multi-cycle unit not ready).
- prog_we  in  1  program write strobe.
- prog_addr  in  STEP_W  program write address.
- prog_data  in  CW_W  control word.
- op_ready  out  1  IDLE, accepts start and program writes.
- busy  out  1  in RUN.
- step  out  STEP_W  current pc.
- fu_sel1, fu_sel2  out  N_FU*SEL_W  unit i uses slice [i*SEL_W +: SEL_W].
- fu_op  out  N_FU*OP_W  unit i uses slice [i*OP_W +: OP_W].
- reg_en  out  N_REG  destination register write enables.
- result_en  out  1  capture final result.
- done  out  1  one-cycle completion pulse.

## Operation
- Word layout, LSB up: fu_sel1, fu_sel2, fu_op, reg_en, result_en, last (MSB). Defaults: [11:0], [23:12], [29:24], [35:30], [36], [37].
- States: IDLE, RUN, DONE.
- IDLE: op_ready=1, all datapath outputs 0, pc=0. start=1 -> RUN.
- RUN: outputs decode mem[pc] combinationally; busy=1; step=pc.
  - stall=1: pc holds; reg_en and result_en forced 0; selects and ops still driven.
  - Not stalled and word.last=0 and pc<DEPTH-1: pc+1.
  - Not stalled and (word.last=1 or pc==DEPTH-1): -> DONE. The last address is an implicit last step.
  - abort=1: has priority over stall and last. All outputs 0 that cycle, -> IDLE, pc=0, no done.
- DONE: done=1, all other outputs 0, -> IDLE.
- Writes: mem[prog_addr] <= prog_data only when op_ready=1; ignored in RUN/DONE.
  - Write and start in the same IDLE cycle: write lands first, and the run sees the new word.
- Memory is not reset. Contents after reset are undefined until loaded; outputs stay 0 outside RUN regardless.
- start in RUN/DONE is ignored. start and abort together in IDLE: start wins (abort is meaningful only in RUN).

## Timing
- Reset values: state IDLE, pc 0, op_ready 1, busy 0, done 0, step 0, all selects/ops/enables 0.
- start high at edge k -> step 0 words visible in cycle k+1.
- L-word program, no stalls: RUN for L cycles, done in cycle k+L+1, op_ready in k+L+2. Each stall cycle adds one.
- Minimum start-to-start interval: L+2 cycles.
- rst mid-RUN: immediate IDLE, outputs 0, no done.

## Structure
- Shared package sched_pkg: state encoding, CW_W function, field offset functions (SEL1_LSB, SEL2_LSB, OP_LSB, REN_LSB, RES_BIT, LAST_BIT) parameterised on N_FU/SEL_W/OP_W/N_REG. The program generator uses the same package.
- Sub-module sched_prog_mem: DEPTH x CW_W, synchronous write, asynchronous read. The top holds the FSM, pc and output gating.

## Test plan
- Reset then idle: all outputs 0, op_ready=1; start with no load is not required to be checked.
- Load a 4-word schedule (word0 sel1 unit0=0, sel2=1, reg_en=6'b000001; word3 last=1, result_en=1, reg_en=6'b100000); start -> step 0..3 in cycles k+1..k+4, exact fields per cycle, done at k+5, op_ready at k+6.
- stall=1 for 2 cycles at step 1 -> step holds at 1, reg_en=0 during stall, done delayed to k+7.
- abort at step 2 -> outputs 0 that cycle, IDLE next, no done pulse; restart runs from step 0.
- 16-word program with no last bit -> runs steps 0..15, done after step 15, no wrap to 0.
- prog_we during RUN to address 0 -> memory unchanged, verified by next run; write plus start in the same IDLE cycle -> new word0 issued at k+1.
